hpdcache_core_req_arbiter: RTL
==============================

# hpdcache_core_req_arbiter

Round-robin arbiter sharing the single HPDcache core request port between NREQ core-side requesters, e.g. CVA6 load/store adapter, AMO path and PTW. It sits between the per-port CVA6 interface adapters and the cache. It overwrites each request's `sid` with the requester index and routes cache responses back by `sid`. It also tracks per-requester outstanding responses so that no requester exceeds a configured response budget.

## Interface
- `NREQ`, default 4: number of requesters, 2..8; must fit in `HPDCACHE_REQ_SRC_ID_WIDTH`.
- `MAX_OUTSTANDING`, default 4: max in-flight `need_rsp=1` requests per requester, 1..15.
- Reset: one clock; reset is synchronous and active-high (`clk_i`, `rst_i`).
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous active-high reset.
- `core_req_valid_i`  in  NREQ  per-requester request valid.
- `core_req_ready_o`  out  NREQ  per-requester request accepted.
- `core_req_i`  in  NREQ x hpdcache_req_t  per-requester request payload.
- `core_rsp_valid_o`  out  NREQ  per-requester response valid.
- `core_rsp_o`  out  hpdcache_rsp_t  response payload, broadcast to all requesters.
- `dcache_req_valid_o`  out  1  request to cache.
- `dcache_req_ready_i`  in  1  cache accepts request.
- `dcache_req_o`  out  hpdcache_req_t  granted payload; `sid` = winner index.
- `dcache_rsp_valid_i`  in  1  cache response valid.
- `dcache_rsp_i`  in  hpdcache_rsp_t  cache response.
- `err_o`  out  1  sticky: an unroutable or unexpected response was dropped.

## Operation
- Eligibility: requester i is eligible when `core_req_valid_i[i]` is set and either `cnt_q[i] < MAX_OUTSTANDING` or `core_req_i[i].need_rsp == 0`.
- Arbitration: among eligible requesters, the first index starting at `rr_q` and scanning upward modulo NREQ wins.
- On handshake:
  - Winner's `core_req_ready_o` is asserted.
  - `rr_q <= (winner+1) % NREQ`.
  - If `need_rsp`, `cnt_q[winner]` increments.
- Lock:
  - Condition: offered request not accepted (`dcache_req_valid_o & ~dcache_req_ready_i`).
  - Effect: `lock_q <= 1`, `lock_idx_q <= winner`.
  - While locked, only `lock_idx_q` is considered, even if a higher-priority requester becomes valid.
  - Lock clears on handshake.
  - Requesters keep valid and payload stable until ready; a valid dropped while locked is a protocol violation (assertion, no recovery).
- Payload: `dcache_req_o` = winner payload, with `sid` replaced by the zero-extended winner index. Every other field passes unmodified.
- Response routing:
  - `core_rsp_valid_o[i] = dcache_rsp_valid_i & (dcache_rsp_i.sid == i) & (cnt_q[i] != 0)`.
  - On a routed response, `cnt_q[i]` decrements.
  - Handshake with `need_rsp` and response for the same requester in one cycle: net count unchanged.
- Dropped responses: a response with `sid >= NREQ` or a zero count is dropped, with no valid on any port, and sets `err_o` until reset.
- Reset values: `rr_q=0`, `lock_q=0`, `cnt_q=0`, `err_o=0`, all `*_valid_o=0`, all `core_req_ready_o=0`.

## Timing
- Default build:
  - Request path is combinational: valid to `dcache_req_valid_o`, and `dcache_req_ready_i` to `core_req_ready_o`.
  - Zero added latency.
- Response path is always combinational with zero latency. There is no response backpressure: the cache response is consumed the same cycle.
- Priority update: `rr_q` and lock take effect the cycle after handshake/stall.
- Reset asserted mid-transaction: all state clears on that edge, and outstanding responses arriving after reset are dropped with `err_o=1`.
- Count wrap is impossible by construction: saturation at MAX_OUTSTANDING masks eligibility.

## Configuration
- Macro: `HPDCACHE_CORE_ARB_OUT_REG_EN`.
- Defined:
  - A one-entry output register sits between arbitration and the cache.
  - `core_req_ready_o[winner] = ~out_full_q | dcache_req_ready_i`.
  - The register loads the winner on upstream handshake, and `dcache_req_*` is driven from the register.
  - Request latency is 1 cycle.
  - `cnt_q` increments at upstream acceptance.
  - Lock is not used: the upstream handshake is always completed or not offered, and `rr_q` advances at upstream acceptance.
  - Register resets empty.
- Undefined: combinational behaviour as described above.

## Test plan
- Simultaneous valids, cache always ready:
  - Stimulus: all 4 valid, each `need_rsp=0`.
  - Response: grants 0,1,2,3,0, one per cycle; `dcache_req_o.sid` matches each grant.
- Lock:
  - Stimulus: req1 valid with `dcache_req_ready_i=0` for 3 cycles; req0 asserts in cycle 2.
  - Response: req1 held, then req1 granted when ready=1; req0 granted next.
- Budget, MAX_OUTSTANDING=2:
  - Stimulus: req2 issues 3 loads with no responses.
  - Response: third held with ready=0. After a response with `sid=2`, `core_rsp_valid_o=4'b0100` and the third is granted.
- Same-cycle handshake and response:
  - Stimulus: req0 with `cnt=1`; in one cycle a `need_rsp` handshake and a `sid=0` response.
  - Response: `cnt` stays 1; the response is routed to port 0.
- Bad response:
  - Stimulus: response with `sid=5`, then separately a response with `sid=1` and count 0.
  - Response: no `core_rsp_valid_o`; `err_o=1`, held through later traffic; cleared only by `rst_i`.
- With `HPDCACHE_CORE_ARB_OUT_REG_EN`:
  - Stimulus: single request in cycle 0, cache ready.
  - Response: `dcache_req_valid_o` in cycle 1. With cache stalled, second request ready=0 while full; a reset mid-stall empties the register.

Source files
------------

// File: rtl/hpdcache_core_req_arbiter.sv
// hpdcache_core_req_arbiter: round-robin arbiter for the HPDcache core request port with sid-based response routing.
// Optional output register stage enabled by defining HPDCACHE_CORE_ARB_OUT_REG_EN.
package hpdcache_core_arb_pkg;
  localparam int HPDCACHE_REQ_SRC_ID_WIDTH = 3;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  op;
    logic [2:0]  size;
    logic [HPDCACHE_REQ_SRC_ID_WIDTH-1:0] sid;
    logic [5:0]  tid;
    logic        need_rsp;
  } hpdcache_req_t;
  typedef struct packed {
    logic [31:0] rdata;
    logic [HPDCACHE_REQ_SRC_ID_WIDTH-1:0] sid;
    logic [5:0]  tid;
    logic        error;
  } hpdcache_rsp_t;
endpackage

module hpdcache_core_req_arbiter
  import hpdcache_core_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] core_req_valid_i,
  output logic [NREQ-1:0] core_req_ready_o,
  input  hpdcache_req_t   core_req_i [NREQ],
  output logic [NREQ-1:0] core_rsp_valid_o,
  output hpdcache_rsp_t   core_rsp_o,
  output logic            dcache_req_valid_o,
  input  logic            dcache_req_ready_i,
  output hpdcache_req_t   dcache_req_o,
  input  logic            dcache_rsp_valid_i,
  input  hpdcache_rsp_t   dcache_rsp_i,
  output logic            err_o
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = HPDCACHE_REQ_SRC_ID_WIDTH;

  logic [IW-1:0]   rr_q, win, scan_idx;
  logic [CW-1:0]   cnt_q [NREQ];
  logic [NREQ-1:0] elig;
  logic            scan_found, found, up_ready, hs, err_q;
  hpdcache_req_t   win_req;

  // A saturated requester may still issue requests that expect no response
  always_comb begin
    for (int i = 0; i < NREQ; i++)
      elig[i] = core_req_valid_i[i] & ((cnt_q[i] < CW'(MAX_OUTSTANDING)) | ~core_req_i[i].need_rsp);
  end

  // Downward scan so the closest eligible index at or after rr_q is written last
  always_comb begin
    scan_idx = rr_q;
    scan_found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (elig[IW'((int'(rr_q) + k) % NREQ)]) begin
        scan_idx = IW'((int'(rr_q) + k) % NREQ);
        scan_found = 1'b1;
      end
    end
  end

  always_comb begin
    win_req = core_req_i[win];
    win_req.sid = SW'(win);
  end

  assign hs = found & up_ready;

  always_comb begin
    core_req_ready_o = '0;
    core_req_ready_o[win] = hs;
  end

`ifdef HPDCACHE_CORE_ARB_OUT_REG_EN
  logic          out_full_q;
  hpdcache_req_t out_q;
  assign win = scan_idx;
  assign found = ~rst_i & scan_found;
  assign up_ready = ~out_full_q | dcache_req_ready_i;
  assign dcache_req_valid_o = out_full_q;
  assign dcache_req_o = out_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) out_full_q <= 1'b0;
    else if (hs) out_full_q <= 1'b1;
    else if (dcache_req_ready_i) out_full_q <= 1'b0;
    if (hs) out_q <= win_req;
  end
`else
  logic          lock_q;
  logic [IW-1:0] lock_idx_q;
  assign win = lock_q ? lock_idx_q : scan_idx;
  assign found = ~rst_i & (lock_q ? elig[lock_idx_q] : scan_found);
  assign up_ready = dcache_req_ready_i;
  assign dcache_req_valid_o = found;
  assign dcache_req_o = win_req;
  // Hold the stalled winner so the cache sees a stable request
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q <= 1'b0;
      lock_idx_q <= '0;
    end else if (found) begin
      lock_q <= ~hs;
      lock_idx_q <= win;
    end
  end
  a_locked_valid_held: assert property (@(posedge clk_i) disable iff (rst_i) lock_q |-> core_req_valid_i[lock_idx_q]);
`endif

  always_comb begin
    for (int i = 0; i < NREQ; i++)
      core_rsp_valid_o[i] = ~rst_i & dcache_rsp_valid_i & (dcache_rsp_i.sid == SW'(i)) & (cnt_q[i] != '0);
  end

  assign core_rsp_o = dcache_rsp_i;
  assign err_o = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      if (dcache_rsp_valid_i & ~|core_rsp_valid_o) err_q <= 1'b1;
      if (hs) rr_q <= IW'((int'(win) + 1) % NREQ);
      for (int i = 0; i < NREQ; i++)
        cnt_q[i] <= cnt_q[i] + CW'(hs & (win == IW'(i)) & win_req.need_rsp) - CW'(core_rsp_valid_o[i]);
    end
  end
endmodule
